demux1h_stream: RTL

DEMUX1H_STREAM -- requirements
Module: demux1h_stream

---
 rtl/demux1h_stream.sv | 110 +++++++++++
 1 files changed

// File: rtl/demux1h_stream.sv
// ---------------------------------------------------------------------------
// demux1h_stream
//
// Routes a valid/ready stream to one of P_CNT output lanes. The lane is chosen
// by a one-hot select vector. Each lane is a single register stage, so a lane
// can take a new word in the same cycle that its current word drains.
// Transfers whose select is not exactly one-hot are still accepted, so the
// upstream never stalls on them. They are then thrown away, counted in a
// saturating drop counter, and recorded in a sticky error flag.
//
// Ports
//   clk                 single clock, all state updates on the rising edge
//   rst_n               asynchronous, active-low reset
//   input_valid         upstream transfer request
//   input_ready         block can accept the presented word this cycle
//   input_payload       P_W-bit data word
//   input_select_vec    one-hot destination lane
//   output_valid_vec    per-lane valid, straight from flops
//   output_ready_vec    per-lane downstream ready
//   output_payload_vec  lane i payload at bits [i*P_W +: P_W], straight from flops
//   drop_cnt            saturating count of discarded illegal-select transfers
//   select_err          sticky flag, set once any illegal select is accepted
// ---------------------------------------------------------------------------
module demux1h_stream #(
    parameter int P_CNT = 4,
    parameter int P_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [P_W-1:0]         input_payload,
    input  logic [P_CNT-1:0]       input_select_vec,
    output logic [P_CNT-1:0]       output_valid_vec,
    input  logic [P_CNT-1:0]       output_ready_vec,
    output logic [P_CNT*P_W-1:0]   output_payload_vec,
    output logic [15:0]            drop_cnt,
    output logic                   select_err
);

    localparam logic [P_CNT-1:0] SEL_ONE = P_CNT'(1);

    logic               sel_legal;
    logic               sel_free;
    logic               xfer;
    logic               drop;
    logic [P_CNT-1:0]   lane_free;
    logic [P_CNT-1:0]   lane_load;
    logic [P_CNT-1:0]   lane_drain;

    // Handshake decode.
    // The select is legal when it has exactly one bit set. Subtracting one
    // clears the lowest set bit, so a nonzero select that becomes zero after
    // that operation has exactly one bit.
    // A lane is free when it is empty or when it drains this cycle. This lets
    // a lane accept a new word while its old word leaves, so there is no
    // bubble between words.
    // Illegal selects always get ready, because they are dropped.
    // input_valid is used only to qualify the transfer, so ready never waits
    // on valid.
    always_comb begin
        sel_legal   = (input_select_vec != '0) &&
                      ((input_select_vec & (input_select_vec - SEL_ONE)) == '0);
        lane_free   = ~output_valid_vec | output_ready_vec;
        sel_free    = |(input_select_vec & lane_free);
        input_ready = ~sel_legal | sel_free;
        xfer        = input_valid & input_ready;
        lane_load   = (xfer && sel_legal) ? input_select_vec : '0;
        lane_drain  = output_valid_vec & output_ready_vec;
        drop        = xfer & ~sel_legal;
    end

    // Lane register stages.
    // A load takes priority over a drain, so a simultaneous drain and load
    // leaves the lane full with the new word.
    // A drain alone clears only the valid bit. The payload keeps its last
    // value, which keeps the data flops from toggling when there is no need.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_valid_vec   <= '0;
            output_payload_vec <= '0;
        end else begin
            for (int i = 0; i < P_CNT; i++) begin
                if (lane_load[i]) begin
                    output_valid_vec[i]                 <= 1'b1;
                    output_payload_vec[i*P_W +: P_W]    <= input_payload;
                end else if (lane_drain[i]) begin
                    output_valid_vec[i]                 <= 1'b0;
                end
            end
        end
    end

    // Bookkeeping for dropped transfers.
    // The counter stops at all-ones instead of wrapping, so a long run of bad
    // selects can never read back as a small count. The error flag can be
    // cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= 16'h0000;
            select_err <= 1'b0;
        end else if (drop) begin
            select_err <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule
